// File: rtl/apb_cmd_master_pkg.sv
// Shared state encoding, command record and register offsets for the APB command master.
package apb_cmd_master_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t StIdle   = 2'd0;
  localparam apb_state_t StSetup  = 2'd1;
  localparam apb_state_t StAccess = 2'd2;
  localparam apb_state_t StResp   = 2'd3;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_cmd_t;

  // Register offsets within one I2S_top instance.
  localparam logic [31:0] CTRL_OFS   = 32'h0;
  localparam logic [31:0] TXDATA_OFS = 32'h4;
  localparam logic [31:0] RXDATA_OFS = 32'h8;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus bundle; master is the initiator's view.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_cmd_master_wait_timer.sv
// Saturating ACCESS-phase wait counter; tc_o flags the last cycle allowed before abort.
module apb_cmd_master_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk_i,
  input  logic preset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(TIMEOUT))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator: command in, SETUP/ACCESS transfer, response out.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             pclk_i,
  input  logic             preset_i,
  apb_cmd_master_if.master bus_io
);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timer_tc;

  apb_cmd_master_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .pclk_i  (pclk_i),
    .preset_i(preset_i),
    .clr_i   (state_q == StSetup),
    .en_i    (state_q == StAccess),
    .tc_o    (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          paddr_d  = bus_io.cmd_addr;
          pwrite_d = bus_io.cmd_write;
          pwdata_d = bus_io.cmd_write ? bus_io.cmd_wdata : '0;
          state_d  = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // pready takes priority over a timeout landing on the same edge.
        if (bus_io.pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus_io.prdata;
          rsp_err_d     = bus_io.pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (timer_tc) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q       <= StIdle;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus_io.cmd_ready   = (state_q == StIdle);
  assign bus_io.psel        = (state_q == StSetup) || (state_q == StAccess);
  assign bus_io.penable     = (state_q == StAccess);
  assign bus_io.pwrite      = pwrite_q;
  assign bus_io.paddr       = paddr_q;
  assign bus_io.pwdata      = pwdata_q;
  assign bus_io.rsp_valid   = (state_q == StResp);
  assign bus_io.rsp_rdata   = rsp_rdata_q;
  assign bus_io.rsp_err     = rsp_err_q;
  assign bus_io.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed table, corner sequences, random transfers.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  localparam int TIMEOUT = 4;

  logic pclk;
  logic preset;
  int   checks;
  int   errors;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_cmd_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk_i  (pclk),
    .preset_i(preset),
    .bus_io  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        serr;
    logic [31:0] rd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: a responder that stalls `waits` cycles.
  function automatic void model(input logic wr, input int waits, input logic serr,
                                input logic [31:0] rd, output logic [31:0] e_rd,
                                output logic e_err, output logic e_to, output int e_acc);
    if (waits < TIMEOUT) begin
      e_acc = waits + 1;
      e_rd  = wr ? 32'h0 : rd;
      e_err = serr;
      e_to  = 1'b0;
    end else begin
      e_acc = TIMEOUT;
      e_rd  = 32'h0;
      e_err = 1'b1;
      e_to  = 1'b1;
    end
  endfunction

  task automatic do_xfer(input vec_t v);
    int          acc;
    logic        done;
    logic [31:0] exp_wd;
    exp_wd = v.wr ? v.wdata : 32'h0;
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom;
    chk("setup_bus", {27'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr == v.addr,
        bus.pwdata == exp_wd}, {27'd0, 1'b1, 1'b0, v.wr, 1'b1, 1'b1});
    step();
    acc  = 0;
    done = 1'b0;
    for (int k = 0; k < TIMEOUT + 2 && !done; k++) begin
      chk("access_bus", {27'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr == v.addr,
          bus.pwdata == exp_wd}, {27'd0, 1'b1, 1'b1, v.wr, 1'b1, 1'b1});
      bus.pready  = (k == v.waits);
      bus.pslverr = (k == v.waits) ? v.serr : 1'($urandom_range(0, 1));
      bus.prdata  = (k == v.waits) ? v.rd : $urandom;
      step();
      acc++;
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      if (bus.rsp_valid) done = 1'b1;
    end
    chk("rsp_valid_seen", 32'(done), 32'd1);
    chk("access_cycles", 32'(acc), 32'(v.exp_acc));
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rd);
    chk("rsp_err_to", {30'd0, bus.rsp_err, bus.rsp_timeout}, {30'd0, v.exp_err, v.exp_to});
    chk("resp_psel", {30'd0, bus.psel, bus.penable}, 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      step();
      chk("hold_rsp", {bus.rsp_rdata ^ v.exp_rd}, 32'd0);
      chk("hold_flags", {27'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.cmd_ready,
          bus.psel}, {27'd0, 1'b1, v.exp_err, v.exp_to, 1'b0, 1'b0});
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_done", {30'd0, bus.rsp_valid, bus.cmd_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  vec_t vecs[7];

  initial begin
    int       n_acc, n_setup, last;
    logic     accept_now;
    apb_cmd_t cmd;
    vec_t     rv;

    checks        = 0;
    errors        = 0;
    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    vecs[0] = '{1'b1, CTRL_OFS,   32'h0000_A5C3, 0,    1'b0, 32'hFFFF_FFFF, 0,
                32'h0,         1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h18,     32'h1111_2222, 2,    1'b0, 32'h1234_5678, 0,
                32'h1234_5678, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, TXDATA_OFS, 32'h0,         0,    1'b1, 32'hDEAD_BEEF, 0,
                32'hDEAD_BEEF, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, RXDATA_OFS, 32'h0,         1000, 1'b0, 32'h5555_5555, 0,
                32'h0,         1'b1, 1'b1, 4};
    vecs[4] = '{1'b1, 32'h10,     32'h0000_0077, 3,    1'b0, 32'h9999_9999, 0,
                32'h0,         1'b0, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h14,     32'h0,         1,    1'b0, 32'hCAFE_F00D, 5,
                32'hCAFE_F00D, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b1, 32'h1C,     32'hABCD_0123, 4,    1'b1, 32'h0,         1,
                32'h0,         1'b1, 1'b1, 4};

    step();
    step();
    chk("reset_bus", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
    chk("reset_paddr", bus.paddr, 32'h0);
    chk("reset_pwdata", bus.pwdata, 32'h0);
    chk("reset_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'h0);
    preset = 1'b0;
    step();
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Back-to-back: three commands with everything ready should issue every 4 cycles.
    bus.pready    = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h100;
    n_acc   = 0;
    n_setup = 0;
    last    = 0;
    for (int c = 0; c < 30 && n_setup < 3; c++) begin
      accept_now = bus.cmd_valid && bus.cmd_ready;
      step();
      if (accept_now) begin
        n_acc++;
        bus.cmd_addr = 32'h100 + 32'(n_acc * 4);
        if (n_acc == 3) bus.cmd_valid = 1'b0;
      end
      if (bus.psel && !bus.penable) begin
        chk("b2b_addr", bus.paddr, 32'h100 + 32'(n_setup * 4));
        if (n_setup > 0) chk("b2b_gap", 32'(c - last), 32'd4);
        last = c;
        n_setup++;
      end
    end
    chk("b2b_count", 32'(n_setup), 32'd3);
    step();
    step();
    step();
    bus.pready    = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("b2b_drained", {30'd0, bus.cmd_ready, bus.psel}, {30'd0, 1'b1, 1'b0});

    // Reset while stalled in ACCESS drops the transfer without a response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h20;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("pre_reset_access", {30'd0, bus.psel, bus.penable}, {30'd0, 1'b1, 1'b1});
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("mid_reset_bus", {29'd0, bus.psel, bus.penable, bus.rsp_valid}, 32'd0);
    chk("mid_reset_paddr", bus.paddr, 32'h0);
    step();
    chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    step();
    chk("post_reset_quiet", {30'd0, bus.rsp_valid, bus.psel}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      cmd.write = 1'($urandom_range(0, 1));
      cmd.addr  = {$urandom_range(0, 255), 2'b00} & 32'h3FF;
      cmd.wdata = $urandom;
      rv.wr     = cmd.write;
      rv.addr   = cmd.addr;
      rv.wdata  = cmd.wdata;
      rv.waits  = $urandom_range(0, TIMEOUT + 2);
      rv.serr   = 1'($urandom_range(0, 1));
      rv.rd     = $urandom;
      rv.hold   = $urandom_range(0, 2);
      model(rv.wr, rv.waits, rv.serr, rv.rd, rv.exp_rd, rv.exp_err, rv.exp_to, rv.exp_acc);
      do_xfer(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
